line_write_addr_former: RTL and testbench
=========================================

Name: line_write_addr_former

Overview:
- Write-side counterpart of the read-side line-number former in the DMA.
- The read side issues expanded even/odd line pairs into the vertical DWT. This block takes the DWT output line pairs (one low-band line, one high-band line per pair) and turns each pair into destination write descriptors for the write DMA.
- Low-band rows are packed at the top of the destination frame and high-band rows below them, with no border-expansion lines.
- It sits between the vertical DWT output stage and the write DMA burst generator.

Parameters:
- ADDR_W, 32, width of byte addresses, line numbers and stride.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- new_frame_i  in  1  start-of-frame strobe; sampled only in Idle.
- vsize_i  in  ADDR_W  number of source lines - 1; sampled with new_frame_i.
- base_addr_i  in  ADDR_W  destination frame byte base address; sampled with new_frame_i.
- stride_i  in  ADDR_W  destination line stride in bytes; sampled with new_frame_i.
- pair_valid_i  in  1  DWT output line pair available.
- pair_ready_o  out  1  pair consumed; high in the cycle its final descriptor handshakes.
- desc_valid_o  out  1  descriptor valid.
- desc_ready_i  in  1  write DMA accepts descriptor.
- desc_addr_o  out  ADDR_W  destination line start address.
- desc_row_o  out  ADDR_W  destination row index.
- desc_band_o  out  1  0 = low band, 1 = high band.
- desc_last_o  out  1  final descriptor of frame; qualified by desc_valid_o.
- busy_o  out  1  high in any state other than Idle.
- frame_done_o  out  1  one-cycle pulse after the last descriptor handshake.

Behaviour:
- Reset (async assert, sync deassert handled at top): state Idle. All outputs are 0 in Idle and after reset; internal counters are 0.
- Frame geometry, latched with new_frame_i in Idle:
  - H = vsize_i + 1.
  - nlow = (vsize_i >> 1) + 1 = ceil(H/2).
  - nhigh = H - nlow = floor(H/2).
  - npairs = nlow.
- States:
  - Idle: on new_frame_i, latch all frame inputs and go to Init. Otherwise stay.
  - Init: exactly one cycle. Compute hi_addr = base + nlow*stride (registered multiply, truncated to ADDR_W). Set lo_addr = base, lo_row = 0, hi_row = nlow, pair_cnt = 0. Go to Low.
  - Low:
    - desc_valid_o = pair_valid_i; addr = lo_addr; row = lo_row; band = 0.
    - On handshake: lo_addr += stride, lo_row += 1.
    - Next state: High if a high line exists for this pair (pair_cnt < nhigh). Otherwise this handshake also asserts pair_ready_o and ends the frame (go to Done).
  - High:
    - desc_valid_o = pair_valid_i; addr = hi_addr; row = hi_row; band = 1.
    - On handshake: pair_ready_o = 1, hi_addr += stride, hi_row += 1, pair_cnt += 1.
    - Next state: Done if pair_cnt + 1 == npairs, else Low.
  - Done: frame_done_o = 1 for one cycle; go to Idle.
- desc_last_o:
  - = 1 in High when pair_cnt == npairs - 1 (H even).
  - = 1 in Low when pair_cnt == nhigh (H odd, final lonely low line).
- Handshake rules:
  - desc_valid_o never asserts without pair_valid_i.
  - A descriptor is held stable (addr/row/band/last) while desc_valid_o && !desc_ready_i.
  - pair_ready_o is combinational: pair_valid_i && desc_ready_i && final-descriptor-of-pair.
- Arithmetic: all address adds wrap modulo 2^ADDR_W. No overflow detection.
- Edge cases:
  - vsize_i = 0: a single low descriptor, last = 1, no high descriptor.
  - new_frame_i outside Idle is ignored; no re-latch.
  - rst_ni asserted mid-frame: immediate return to Idle; the partial frame is abandoned with no frame_done_o.
  - new_frame_i in the same cycle as Done: ignored; it is accepted only in Idle.

Decomposition:
- Shared dma package holds:
  - addr_t (logic [ADDR_W-1:0]).
  - band_t enum {BandLow, BandHigh}.
  - state typedef {Idle, Init, Low, High, Done}.
- One natural sub-module: line_addr_accum (stride accumulator with load/step, ADDR_W wide), instantiated twice for the low and high address/row pairs.

Test Plan:
- vsize=7, base=0x1000, stride=0x100, pair_valid held high, desc_ready high:
  - Descriptors L0 0x1000 r0, H0 0x1400 r4, L1 0x1100 r1, H1 0x1500 r5, …, H3 0x1700 r7.
  - desc_last_o only on H3; 4 pair_ready_o pulses; frame_done_o one cycle later.
- vsize=6, same base/stride: nlow=4, H0 at 0x1400. Final descriptor is L3 0x1300 r3 with last=1; no H3; 4 pair_ready_o pulses.
- vsize=0: one descriptor, addr=base, row 0, band 0, last=1; busy_o drops after Done.
- Random desc_ready_i and pair_valid_i gaps with vsize=7: descriptor fields stable while stalled; sequence identical to the first case; no descriptor without pair_valid_i.
- new_frame_i pulsed mid-frame with different vsize/base: ignored; the current frame completes with the original values.
- rst_ni low after H1 handshake: outputs 0 immediately. A fresh frame (vsize=3, base=0x2000, stride=0x40) then gives L0 0x2000, H0 0x2080, L1 0x2040, H1 0x20C0 (last).

Source files
------------

// File: rtl/line_write_addr_former_pkg.sv
// Shared write-DMA types for the line write address former: address type,
// band encoding and FSM state constants.
package line_write_addr_former_pkg;

   localparam int unsigned DMA_ADDR_W = 32;

   typedef logic [DMA_ADDR_W-1:0] addr_t;

   // Destination band of a descriptor: low-band rows are packed first.
   typedef enum logic {
      BAND_LOW  = 1'b0,
      BAND_HIGH = 1'b1
   } band_t;

   // FSM state encoding kept as plain constants for legacy compatibility.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_INIT = 3'd1;
   localparam state_t ST_LOW  = 3'd2;
   localparam state_t ST_HIGH = 3'd3;
   localparam state_t ST_DONE = 3'd4;

endpackage : line_write_addr_former_pkg

// File: rtl/line_write_addr_former_line_addr_accum.sv
// Stride accumulator: holds a destination byte address and its row index.
// load_i preloads both; step_i advances the address by one stride and the
// row by one. All arithmetic wraps modulo 2^ADDR_W.
module line_addr_accum #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [ADDR_W-1:0] load_row_i,
   input  logic [ADDR_W-1:0] stride_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ADDR_W-1:0] row_o
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   // Address/row register: load takes priority over step.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking (<=) in clocked blocks so every register updates
      // from pre-edge values regardless of statement order.
      if (!rst_ni) begin
         addr_o <= '0;
         row_o  <= '0;
      end else if (load_i) begin
         addr_o <= load_addr_i;
         row_o  <= load_row_i;
      end else if (step_i) begin
         addr_o <= addr_o + stride_i;
         row_o  <= row_o + ONE;
      end
   end

endmodule : line_addr_accum

// File: rtl/line_write_addr_former.sv
// Line write address former: turns vertical-DWT output line pairs (one low
// band line, one high band line) into write-DMA descriptors. Low-band rows
// are packed at the top of the destination frame, high-band rows below.
module line_write_addr_former
   import line_write_addr_former_pkg::*;
#(
   parameter int unsigned ADDR_W = DMA_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              new_frame_i,
   input  logic [ADDR_W-1:0] vsize_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] stride_i,
   input  logic              pair_valid_i,
   output logic              pair_ready_o,
   output logic              desc_valid_o,
   input  logic              desc_ready_i,
   output logic [ADDR_W-1:0] desc_addr_o,
   output logic [ADDR_W-1:0] desc_row_o,
   output logic              desc_band_o,
   output logic              desc_last_o,
   output logic              busy_o,
   output logic              frame_done_o
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] nlow_q, nhigh_q, stride_q, base_q, pair_cnt_q;
   logic [ADDR_W-1:0] lo_addr, lo_row, hi_addr, hi_row;
   logic [ADDR_W-1:0] hi_start;
   logic              hs, has_high, last_pair, init_load, lo_step, hi_step;
   band_t             band;

   assign hs        = desc_valid_o && desc_ready_i;
   assign has_high  = pair_cnt_q < nhigh_q;
   assign last_pair = (pair_cnt_q + ONE) == nlow_q;
   assign init_load = state_q == ST_INIT;
   assign lo_step   = (state_q == ST_LOW) && hs;
   assign hi_step   = (state_q == ST_HIGH) && hs;

   // High band starts right after the nlow packed low-band rows.
   assign hi_start  = base_q + nlow_q * stride_q;

   // Low-band address/row walker.
   line_addr_accum #(.ADDR_W(ADDR_W)) u_lo_accum (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (init_load),
      .step_i      (lo_step),
      .load_addr_i (base_q),
      .load_row_i  ('0),
      .stride_i    (stride_q),
      .addr_o      (lo_addr),
      .row_o       (lo_row)
   );

   // High-band address/row walker.
   line_addr_accum #(.ADDR_W(ADDR_W)) u_hi_accum (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (init_load),
      .step_i      (hi_step),
      .load_addr_i (hi_start),
      .load_row_i  (nlow_q),
      .stride_i    (stride_q),
      .addr_o      (hi_addr),
      .row_o       (hi_row)
   );

   // Latch frame geometry on an accepted start-of-frame (Idle only).
   // nlow = ceil(H/2) = (vsize>>1)+1, nhigh = H - nlow = vsize - (vsize>>1).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nlow_q   <= '0;
         nhigh_q  <= '0;
         stride_q <= '0;
         base_q   <= '0;
      end else if ((state_q == ST_IDLE) && new_frame_i) begin
         nlow_q   <= (vsize_i >> 1) + ONE;
         nhigh_q  <= vsize_i - (vsize_i >> 1);
         stride_q <= stride_i;
         base_q   <= base_addr_i;
      end
   end

   // Count completed pairs; a pair completes on its high-band handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pair_cnt_q <= '0;
      end else if (init_load) begin
         pair_cnt_q <= '0;
      end else if (hi_step) begin
         pair_cnt_q <= pair_cnt_q + ONE;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: alternate Low/High per pair, Done after the last line.
   always_comb begin
      // NOTE: default every combinationally assigned signal first so no
      // path through the case leaves it unassigned (which would infer a latch).
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (new_frame_i) state_d = ST_INIT;
         ST_INIT: state_d = ST_LOW;
         ST_LOW:  if (hs) state_d = has_high ? ST_HIGH : ST_DONE;
         ST_HIGH: if (hs) state_d = last_pair ? ST_DONE : ST_LOW;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Descriptor outputs; all zero outside Low/High. Fields depend only on
   // registered state, so they stay stable while a descriptor is stalled.
   always_comb begin
      desc_valid_o = 1'b0;
      desc_addr_o  = '0;
      desc_row_o   = '0;
      band         = BAND_LOW;
      desc_last_o  = 1'b0;
      pair_ready_o = 1'b0;
      case (state_q)
         ST_LOW: begin
            desc_valid_o = pair_valid_i;
            desc_addr_o  = lo_addr;
            desc_row_o   = lo_row;
            desc_last_o  = pair_cnt_q == nhigh_q;
            pair_ready_o = pair_valid_i && desc_ready_i && !has_high;
         end
         ST_HIGH: begin
            desc_valid_o = pair_valid_i;
            desc_addr_o  = hi_addr;
            desc_row_o   = hi_row;
            band         = BAND_HIGH;
            desc_last_o  = last_pair;
            pair_ready_o = pair_valid_i && desc_ready_i;
         end
         default: ;
      endcase
   end

   assign desc_band_o  = logic'(band);
   assign busy_o       = state_q != ST_IDLE;
   assign frame_done_o = state_q == ST_DONE;

endmodule : line_write_addr_former

// File: tb/tb_line_write_addr_former.sv
// Self-checking bench for line_write_addr_former: directed table of frames
// with expected constants, a reset-abort sequence, and randomized frames
// checked against an expected-descriptor list built from the frame geometry.
module tb_line_write_addr_former;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        new_frame_i;
   logic [31:0] vsize_i, base_addr_i, stride_i;
   logic        pair_valid_i, pair_ready_o;
   logic        desc_valid_o, desc_ready_i;
   logic [31:0] desc_addr_o, desc_row_o;
   logic        desc_band_o, desc_last_o, busy_o, frame_done_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] row;
      logic        band;
      logic        last;
      logic        pr;
   } desc_t;

   typedef struct {
      logic [31:0] vs, b, st;
      int          vpct, rpct;
      bit          inject;
      int          exp_n, exp_npr;
      logic [31:0] exp_last_addr, exp_last_row, exp_h0;
      logic        exp_last_band;
   } vec_t;

   always #5 clk_i = ~clk_i;

   line_write_addr_former #(.ADDR_W(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .new_frame_i  (new_frame_i),
      .vsize_i      (vsize_i),
      .base_addr_i  (base_addr_i),
      .stride_i     (stride_i),
      .pair_valid_i (pair_valid_i),
      .pair_ready_o (pair_ready_o),
      .desc_valid_o (desc_valid_o),
      .desc_ready_i (desc_ready_i),
      .desc_addr_o  (desc_addr_o),
      .desc_row_o   (desc_row_o),
      .desc_band_o  (desc_band_o),
      .desc_last_o  (desc_last_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // All outputs must be zero (Idle / reset), even with pair_valid_i high.
   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, 32'(desc_valid_o), 32'd0);
      check({tag, "_busy"},  32'(busy_o), 32'd0);
      check({tag, "_done"},  32'(frame_done_o), 32'd0);
      check({tag, "_pready"}, 32'(pair_ready_o), 32'd0);
      check({tag, "_addr"},  desc_addr_o, 32'd0);
      check({tag, "_row"},   desc_row_o, 32'd0);
      check({tag, "_last"},  32'({desc_band_o, desc_last_o}), 32'd0);
   endtask

   // Expected descriptor order: pair k gives low row k at base+k*stride, then
   // (if it exists) high row nlow+k at base+(nlow+k)*stride.
   task automatic build_model(input logic [31:0] vs, b, st, output desc_t q[$]);
      logic [31:0] h, nlow, nhigh;
      desc_t d;
      q = {};
      h     = vs + 32'd1;
      nlow  = (h + 32'd1) / 32'd2;
      nhigh = h / 32'd2;
      for (int k = 0; k < int'(nlow); k++) begin
         d.addr = b + 32'(k) * st;
         d.row  = 32'(k);
         d.band = 1'b0;
         d.last = 1'b0;
         d.pr   = 32'(k) >= nhigh;
         q.push_back(d);
         if (32'(k) < nhigh) begin
            d.addr = b + (nlow + 32'(k)) * st;
            d.row  = nlow + 32'(k);
            d.band = 1'b1;
            d.pr   = 1'b1;
            q.push_back(d);
         end
      end
      d = q.pop_back();
      d.last = 1'b1;
      q.push_back(d);
   endtask

   // Runs one frame starting at a negedge in Idle. abort_after >= 0 asserts
   // reset after that many descriptor handshakes instead of finishing.
   task automatic do_frame(input logic [31:0] vs, b, st, input int vpct, rpct,
                           input bit inject, input int abort_after,
                           output int n_desc, output int n_pr,
                           output logic [31:0] last_addr, last_row, h0_addr,
                           output logic last_band);
      desc_t q[$];
      int    hs_cnt = 0;
      int    budget;
      bit    h0_seen = 1'b0;
      bit    hs_exp;
      n_desc = 0; n_pr = 0; last_addr = '0; last_row = '0; h0_addr = '0; last_band = 1'b0;
      build_model(vs, b, st, q);

      // Idle: present the frame.
      new_frame_i = 1'b1; vsize_i = vs; base_addr_i = b; stride_i = st;
      pair_valid_i = 1'b1; desc_ready_i = 1'b1;
      #4;
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_valid", 32'(desc_valid_o), 32'd0);
      @(negedge clk_i);

      // Init: one cycle, no descriptor yet.
      new_frame_i = 1'b0; vsize_i = $urandom; base_addr_i = $urandom; stride_i = $urandom;
      #4;
      check("init_busy", 32'(busy_o), 32'd1);
      check("init_valid", 32'(desc_valid_o), 32'd0);
      @(negedge clk_i);

      budget = 50 + 20 * q.size();
      for (int cyc = 0; cyc < budget && q.size() > 0; cyc++) begin
         pair_valid_i = $urandom_range(99) < vpct;
         desc_ready_i = $urandom_range(99) < rpct;
         new_frame_i  = inject && (cyc == 2);
         vsize_i      = $urandom_range(1, 30);
         base_addr_i  = $urandom;
         stride_i     = $urandom;
         #4;
         hs_exp = pair_valid_i && desc_ready_i;
         check("valid", 32'(desc_valid_o), 32'(pair_valid_i));
         check("busy", 32'(busy_o), 32'd1);
         check("done_early", 32'(frame_done_o), 32'd0);
         check("pair_ready", 32'(pair_ready_o), 32'(hs_exp && q[0].pr));
         if (pair_valid_i) begin
            check("addr", desc_addr_o, q[0].addr);
            check("row", desc_row_o, q[0].row);
            check("band", 32'(desc_band_o), 32'(q[0].band));
            check("last", 32'(desc_last_o), 32'(q[0].last));
         end
         if (desc_valid_o && desc_ready_i) begin
            n_desc++;
            if (desc_band_o && !h0_seen) begin
               h0_seen = 1'b1;
               h0_addr = desc_addr_o;
            end
            if (desc_last_o) begin
               last_addr = desc_addr_o;
               last_row  = desc_row_o;
               last_band = desc_band_o;
            end
         end
         if (pair_ready_o) n_pr++;
         if (hs_exp) begin
            void'(q.pop_front());
            hs_cnt++;
         end
         @(negedge clk_i);
         if (abort_after >= 0 && hs_cnt == abort_after) break;
      end
      new_frame_i = 1'b0;

      if (abort_after >= 0) begin
         // Mid-frame reset: outputs drop at once, no frame_done afterwards.
         check("abort_reached", 32'(hs_cnt), 32'(abort_after));
         pair_valid_i = 1'b1; desc_ready_i = 1'b1;
         rst_ni = 1'b0;
         #1;
         check_quiet("abort");
         @(negedge clk_i);
         rst_ni = 1'b1;
         #4;
         check("abort_no_done", 32'(frame_done_o), 32'd0);
         check("abort_idle", 32'(busy_o), 32'd0);
         @(negedge clk_i);
         return;
      end

      check("timeout_left", 32'(q.size()), 32'd0);

      // Done: one-cycle pulse; a new_frame here must be ignored.
      pair_valid_i = 1'b1; desc_ready_i = 1'b1;
      new_frame_i = 1'b1; vsize_i = 32'd5; base_addr_i = 32'hDEAD_0000; stride_i = 32'd8;
      #4;
      check("done_pulse", 32'(frame_done_o), 32'd1);
      check("done_busy", 32'(busy_o), 32'd1);
      check("done_valid", 32'(desc_valid_o), 32'd0);
      @(negedge clk_i);
      new_frame_i = 1'b0;
      #4;
      check_quiet("post_done");
      @(negedge clk_i);
   endtask

   vec_t vecs[7];
   int          n_desc, n_pr;
   logic [31:0] last_addr, last_row, h0_addr;
   logic        last_band;

   initial begin
      //            vs     base           stride   v%   r%  inj  n  npr  last_addr      last_row  h0             band
      vecs[0] = '{32'd7, 32'h1000,      32'h100, 100, 100, 0,  8, 4, 32'h1700,      32'd7, 32'h1400,      1'b1};
      vecs[1] = '{32'd6, 32'h1000,      32'h100, 100, 100, 0,  7, 4, 32'h1300,      32'd3, 32'h1400,      1'b0};
      vecs[2] = '{32'd0, 32'h1000,      32'h100, 100, 100, 0,  1, 1, 32'h1000,      32'd0, 32'h0,         1'b0};
      vecs[3] = '{32'd7, 32'h1000,      32'h100,  60,  50, 0,  8, 4, 32'h1700,      32'd7, 32'h1400,      1'b1};
      vecs[4] = '{32'd7, 32'h1000,      32'h100,  80,  70, 1,  8, 4, 32'h1700,      32'd7, 32'h1400,      1'b1};
      vecs[5] = '{32'd3, 32'hFFFF_FF80, 32'h40,  100, 100, 0,  4, 2, 32'h0000_0040, 32'd3, 32'h0,         1'b1};
      vecs[6] = '{32'd3, 32'h2000,      32'h40,  100, 100, 0,  4, 2, 32'h20C0,      32'd3, 32'h2080,      1'b1};

      // Reset with active-looking inputs: everything must stay quiet.
      rst_ni = 1'b0; new_frame_i = 1'b1; pair_valid_i = 1'b1; desc_ready_i = 1'b1;
      vsize_i = 32'd7; base_addr_i = 32'h1000; stride_i = 32'h100;
      repeat (3) @(negedge clk_i);
      #4;
      check_quiet("reset");
      @(negedge clk_i);
      rst_ni = 1'b1; new_frame_i = 1'b0;
      @(negedge clk_i);

      for (int i = 0; i < 6; i++) begin
         do_frame(vecs[i].vs, vecs[i].b, vecs[i].st, vecs[i].vpct, vecs[i].rpct,
                  vecs[i].inject, -1, n_desc, n_pr, last_addr, last_row, h0_addr, last_band);
         check($sformatf("v%0d_ndesc", i), 32'(n_desc), 32'(vecs[i].exp_n));
         check($sformatf("v%0d_npr", i), 32'(n_pr), 32'(vecs[i].exp_npr));
         check($sformatf("v%0d_last_addr", i), last_addr, vecs[i].exp_last_addr);
         check($sformatf("v%0d_last_row", i), last_row, vecs[i].exp_last_row);
         check($sformatf("v%0d_last_band", i), 32'(last_band), 32'(vecs[i].exp_last_band));
         check($sformatf("v%0d_h0", i), h0_addr, vecs[i].exp_h0);
      end

      // Abort after H1 handshake, then a fresh frame.
      do_frame(32'd7, 32'h1000, 32'h100, 100, 100, 1'b0, 4,
               n_desc, n_pr, last_addr, last_row, h0_addr, last_band);
      do_frame(vecs[6].vs, vecs[6].b, vecs[6].st, vecs[6].vpct, vecs[6].rpct,
               vecs[6].inject, -1, n_desc, n_pr, last_addr, last_row, h0_addr, last_band);
      check("fresh_ndesc", 32'(n_desc), 32'(vecs[6].exp_n));
      check("fresh_npr", 32'(n_pr), 32'(vecs[6].exp_npr));
      check("fresh_last_addr", last_addr, vecs[6].exp_last_addr);
      check("fresh_last_row", last_row, vecs[6].exp_last_row);
      check("fresh_h0", h0_addr, vecs[6].exp_h0);

      // Randomized frames against the descriptor-list model.
      for (int i = 0; i < 8; i++) begin
         do_frame(32'($urandom_range(0, 20)), $urandom, 32'($urandom_range(0, 4095)),
                  int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                  1'($urandom_range(0, 1)), -1,
                  n_desc, n_pr, last_addr, last_row, h0_addr, last_band);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_line_write_addr_former
